// File: rtl/cacheline_adapter.sv
// cacheline_adapter
//   Sits directly downstream of the data cache dfp port. One 256-bit line
//   read or write becomes a 4-beat, 64-bit burst on the banked-memory side;
//   a single-cycle dfp_resp marks completion. One transaction in flight.
//
// Configuration macro:
//   CACHELINE_ADAPTER_RADDR_FILTER_EN - when defined, a returning read beat is
//   accepted only if its bmem_raddr line tag matches the requested line.
//   When undefined, bmem_raddr is ignored.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   dfp_addr      line address from cache (low OFFSET_BITS ignored)
//   dfp_read      line read request, held until dfp_resp
//   dfp_write     line write request, held until dfp_resp (wins over read)
//   dfp_wdata     line to write, sampled when the request is accepted
//   dfp_rdata     last assembled read line; valid while dfp_resp=1
//   dfp_resp      one-cycle completion pulse
//   bmem_addr     line-aligned burst address
//   bmem_read     burst read command (high only while waiting for accept)
//   bmem_write    write beat valid
//   bmem_wdata    write beat data
//   bmem_ready    memory accepts command/beat this cycle
//   bmem_raddr    line tag of returning read beat
//   bmem_rdata    read beat data
//   bmem_rvalid   read beat valid
//   state_dbg     current FSM state encoding
//
// Handshake: a command or write beat transfers on a cycle where the adapter
// drives bmem_read/bmem_write high and bmem_ready is high; while bmem_ready is
// low the adapter holds command, address and data unchanged. Read beats
// transfer on every bmem_rvalid cycle in RD_DATA with no back-pressure.
module cacheline_adapter #(
    parameter int LINE_BITS   = 256,
    parameter int BEAT_BITS   = 64,
    parameter int BEATS       = LINE_BITS / BEAT_BITS,
    parameter int OFFSET_BITS = $clog2(LINE_BITS / 8)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          dfp_addr,
    input  logic                 dfp_read,
    input  logic                 dfp_write,
    input  logic [LINE_BITS-1:0] dfp_wdata,
    output logic [LINE_BITS-1:0] dfp_rdata,
    output logic                 dfp_resp,
    output logic [31:0]          bmem_addr,
    output logic                 bmem_read,
    output logic                 bmem_write,
    output logic [BEAT_BITS-1:0] bmem_wdata,
    input  logic                 bmem_ready,
    input  logic [31:0]          bmem_raddr,
    input  logic [BEAT_BITS-1:0] bmem_rdata,
    input  logic                 bmem_rvalid,
    output logic [2:0]           state_dbg
);

    localparam int CNT_BITS = $clog2(BEATS);
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_DATA  = 3'd2,
        WR_BURST = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [31:0]           addr_q;
    logic [LINE_BITS-1:0]  wbuf_q;
    logic [LINE_BITS-1:0]  rbuf_q;
    logic [LINE_BITS-1:0]  rdata_q;
    logic [LINE_BITS-1:0]  rbuf_ins;
    logic                  accept_req;
    logic                  take_beat;
    logic                  beat_ok;

`ifdef CACHELINE_ADAPTER_RADDR_FILTER_EN
    assign beat_ok = (bmem_raddr[31:OFFSET_BITS] == addr_q[31:OFFSET_BITS]);
    wire unused_ok = &{1'b0, bmem_raddr[OFFSET_BITS-1:0], dfp_addr[OFFSET_BITS-1:0]};
`else
    assign beat_ok = 1'b1;
    wire unused_ok = &{1'b0, bmem_raddr, dfp_addr[OFFSET_BITS-1:0]};
`endif

    // Line being assembled with the current beat dropped into its slot. On the
    // final beat this is the complete line, so the output register can load it
    // in the same edge that enters RESP.
    always_comb begin
        rbuf_ins = rbuf_q;
        rbuf_ins[cnt_q*BEAT_BITS +: BEAT_BITS] = bmem_rdata;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;
        dfp_resp   = 1'b0;
        accept_req = 1'b0;
        take_beat  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dfp_write) begin
                    accept_req = 1'b1;
                    cnt_d      = '0;
                    state_d    = WR_BURST;
                end else if (dfp_read) begin
                    accept_req = 1'b1;
                    state_d    = RD_REQ;
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                if (bmem_ready) begin
                    cnt_d   = '0;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (bmem_rvalid && beat_ok) begin
                    take_beat = 1'b1;
                    cnt_d     = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_BEAT) state_d = RESP;
                end
            end
            WR_BURST: begin
                bmem_write = 1'b1;
                bmem_wdata = wbuf_q[cnt_q*BEAT_BITS +: BEAT_BITS];
                if (bmem_ready) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_BEAT) state_d = RESP;
                end
            end
            RESP: begin
                dfp_resp = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept_req) begin
                addr_q <= {dfp_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                wbuf_q <= dfp_wdata;
            end
            if (take_beat) begin
                rbuf_q <= rbuf_ins;
                if (cnt_q == LAST_BEAT) rdata_q <= rbuf_ins;
            end
        end
    end

    assign bmem_addr = addr_q;
    assign dfp_rdata = rdata_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
module tb_cacheline_adapter;

    logic         clk;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;
    logic [2:0]   state_dbg;

    int checks = 0;
    int errors = 0;

    cacheline_adapter dut (
        .clk        (clk),
        .rst        (rst),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1ns after each rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++; if (dfp_resp !== 1'b0) begin errors++; $display("FAIL rst_resp got %0b exp 0", dfp_resp); end
        checks++; if (dfp_rdata !== 256'd0) begin errors++; $display("FAIL rst_rdata got %h exp 0", dfp_rdata); end
        checks++; if (bmem_read !== 1'b0) begin errors++; $display("FAIL rst_bmem_read got %0b exp 0", bmem_read); end
        checks++; if (bmem_write !== 1'b0) begin errors++; $display("FAIL rst_bmem_write got %0b exp 0", bmem_write); end
        checks++; if (bmem_addr !== 32'd0) begin errors++; $display("FAIL rst_bmem_addr got %h exp 0", bmem_addr); end
        checks++; if (bmem_wdata !== 64'd0) begin errors++; $display("FAIL rst_bmem_wdata got %h exp 0", bmem_wdata); end
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state_dbg); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_read_basic;
        logic [63:0]  b [4];
        logic [255:0] exp_line;
        b[0] = {4{16'h1111}}; b[1] = {4{16'h2222}};
        b[2] = {4{16'h3333}}; b[3] = {4{16'h4444}};
        exp_line = {b[3], b[2], b[1], b[0]};
        bmem_ready = 1'b1;
        bmem_raddr = 32'h0000_1220;
        dfp_addr   = 32'h0000_1234;
        dfp_read   = 1'b1;                         // cycle 0
        tick;                                      // cycle 1
        checks++; if (bmem_read !== 1'b1) begin errors++; $display("FAIL rd_cmd got %0b exp 1", bmem_read); end
        checks++; if (bmem_addr !== 32'h0000_1220) begin errors++; $display("FAIL rd_addr got %h exp 00001220", bmem_addr); end
        for (int i = 0; i < 4; i++) begin          // beats at cycles 2..5
            tick;
            bmem_rvalid = 1'b1;
            bmem_rdata  = b[i];
            if (i == 0) begin
                checks++; if (bmem_read !== 1'b0) begin errors++; $display("FAIL rd_cmd_drop got %0b exp 0", bmem_read); end
            end
            if (i == 3) begin
                checks++; if (dfp_resp !== 1'b0) begin errors++; $display("FAIL rd_resp_early got %0b exp 0", dfp_resp); end
            end
        end
        tick;                                      // cycle 6
        bmem_rvalid = 1'b0;
        checks++; if (dfp_resp !== 1'b1) begin errors++; $display("FAIL rd_resp_c6 got %0b exp 1", dfp_resp); end
        checks++; if (dfp_rdata !== exp_line) begin errors++; $display("FAIL rd_line got %h exp %h", dfp_rdata, exp_line); end
        dfp_read = 1'b0;
        tick;                                      // cycle 7
        checks++; if (dfp_resp !== 1'b0) begin errors++; $display("FAIL rd_resp_pulse got %0b exp 0", dfp_resp); end
        checks++; if (dfp_rdata !== exp_line) begin errors++; $display("FAIL rd_line_hold got %h exp %h", dfp_rdata, exp_line); end
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL rd_idle got %0d exp 0", state_dbg); end
    endtask

    task automatic test_write_stall;
        logic [63:0]  d [4];
        logic [63:0]  exp_w [6];
        logic [5:0]   rdy_pat;
        logic [255:0] prev_line;
        d[0] = 64'hD0D0_0000_0000_00D0; d[1] = 64'hD1D1_1111_1111_11D1;
        d[2] = 64'hD2D2_2222_2222_22D2; d[3] = 64'hD3D3_3333_3333_33D3;
        exp_w[0] = d[0]; exp_w[1] = d[1]; exp_w[2] = d[1];
        exp_w[3] = d[1]; exp_w[4] = d[2]; exp_w[5] = d[3];
        rdy_pat   = 6'b111001;
        prev_line = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
        dfp_addr  = 32'h8000_0040;
        dfp_wdata = {d[3], d[2], d[1], d[0]};
        dfp_write = 1'b1;                          // cycle 0
        for (int i = 0; i < 6; i++) begin          // cycles 1..6
            tick;
            bmem_ready = rdy_pat[i];
            if (i == 1) begin
                dfp_addr  = 32'hFFFF_FFE0;         // changes after acceptance are ignored
                dfp_wdata = '1;
            end
            checks++; if (bmem_write !== 1'b1) begin errors++; $display("FAIL wr_valid[%0d] got %0b exp 1", i, bmem_write); end
            checks++; if (bmem_addr !== 32'h8000_0040) begin errors++; $display("FAIL wr_addr[%0d] got %h exp 80000040", i, bmem_addr); end
            checks++; if (bmem_wdata !== exp_w[i]) begin errors++; $display("FAIL wr_data[%0d] got %h exp %h", i, bmem_wdata, exp_w[i]); end
        end
        tick;                                      // cycle 7
        checks++; if (dfp_resp !== 1'b1) begin errors++; $display("FAIL wr_resp_c7 got %0b exp 1", dfp_resp); end
        checks++; if (bmem_write !== 1'b0) begin errors++; $display("FAIL wr_valid_drop got %0b exp 0", bmem_write); end
        checks++; if (dfp_rdata !== prev_line) begin errors++; $display("FAIL wr_rdata_hold got %h exp %h", dfp_rdata, prev_line); end
        dfp_write = 1'b0;
        tick;
    endtask

    task automatic test_read_stalls;
        logic [63:0]  b [4];
        logic [255:0] exp_line;
        logic [255:0] got_line;
        int rcnt, resp_cnt, resp_cyc, bi;
        b[0] = 64'hA0A0_0101_0202_0303; b[1] = 64'hA1A1_1414_1515_1616;
        b[2] = 64'hA2A2_2727_2828_2929; b[3] = 64'hA3A3_3A3A_3B3B_3C3C;
        exp_line = {b[3], b[2], b[1], b[0]};
        rcnt = 0; resp_cnt = 0; resp_cyc = -1; bi = 0; got_line = '0;
        bmem_ready = 1'b0;
        bmem_raddr = 32'h0000_2000;
        dfp_addr   = 32'h0000_2008;
        dfp_read   = 1'b1;                         // cycle 0
        for (int c = 1; c <= 16; c++) begin
            tick;
            if (bmem_read) rcnt++;
            if (c == 1) begin
                checks++; if (bmem_addr !== 32'h0000_2000) begin errors++; $display("FAIL rs_addr got %h exp 00002000", bmem_addr); end
            end
            if (dfp_resp) begin
                resp_cnt++;
                resp_cyc = c;
                got_line = dfp_rdata;
                dfp_read = 1'b0;
            end
            bmem_ready = (c >= 4);
            if (c == 6 || c == 8 || c == 9 || c == 12) begin
                bmem_rvalid = 1'b1;
                bmem_rdata  = b[bi];
                bi++;
            end else if (c == 2) begin
                bmem_rvalid = 1'b1;                // stray beat while still in RD_REQ
                bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
            end else begin
                bmem_rvalid = 1'b0;
                bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            end
        end
        bmem_rvalid = 1'b0;
        checks++; if (rcnt != 4) begin errors++; $display("FAIL rs_cmd_cycles got %0d exp 4", rcnt); end
        checks++; if (resp_cnt != 1) begin errors++; $display("FAIL rs_resp_count got %0d exp 1", resp_cnt); end
        checks++; if (resp_cyc != 13) begin errors++; $display("FAIL rs_resp_cycle got %0d exp 13", resp_cyc); end
        checks++; if (got_line !== exp_line) begin errors++; $display("FAIL rs_line got %h exp %h", got_line, exp_line); end
    endtask

    task automatic test_both_requests;
        int rcnt, wcnt, resp_cnt, resp_cyc;
        rcnt = 0; wcnt = 0; resp_cnt = 0; resp_cyc = -1;
        bmem_ready = 1'b1;
        dfp_addr   = 32'h0000_3010;
        dfp_wdata  = {64'h4, 64'h3, 64'h2, 64'h1};
        dfp_read   = 1'b1;
        dfp_write  = 1'b1;                         // cycle 0
        for (int c = 1; c <= 8; c++) begin
            tick;
            if (bmem_read) rcnt++;
            if (bmem_write) begin
                wcnt++;
                if (c == 1) begin
                    checks++; if (bmem_addr !== 32'h0000_3000) begin errors++; $display("FAIL both_addr got %h exp 00003000", bmem_addr); end
                end
            end
            if (dfp_resp) begin
                resp_cnt++;
                resp_cyc  = c;
                dfp_read  = 1'b0;
                dfp_write = 1'b0;
            end
        end
        checks++; if (rcnt != 0) begin errors++; $display("FAIL both_no_read got %0d exp 0", rcnt); end
        checks++; if (wcnt != 4) begin errors++; $display("FAIL both_write_beats got %0d exp 4", wcnt); end
        checks++; if (resp_cyc != 5) begin errors++; $display("FAIL both_resp_cycle got %0d exp 5", resp_cyc); end
        checks++; if (resp_cnt != 1) begin errors++; $display("FAIL both_resp_count got %0d exp 1", resp_cnt); end
    endtask

    task automatic test_reset_mid_burst;
        logic [63:0]  b [4];
        logic [255:0] exp_line;
        b[0] = 64'h5000_0000_0000_0005; b[1] = 64'h5111_0000_0000_1115;
        b[2] = 64'h5222_0000_0000_2225; b[3] = 64'h5333_0000_0000_3335;
        exp_line = {b[3], b[2], b[1], b[0]};
        bmem_ready = 1'b1;
        dfp_addr   = 32'h0000_4000;
        dfp_wdata  = {64'hCC33, 64'hCC22, 64'hCC11, 64'hCC00};
        dfp_write  = 1'b1;                         // cycle 0
        tick;                                      // cycle 1: beat 0
        tick;                                      // cycle 2: beat 1
        tick;                                      // cycle 3: beat 2 presented
        checks++; if (bmem_wdata !== 64'hCC22) begin errors++; $display("FAIL rm_beat2 got %h exp cc22", bmem_wdata); end
        rst        = 1'b1;
        dfp_write  = 1'b0;
        bmem_ready = 1'b0;
        tick;                                      // cycle 4
        rst = 1'b0;
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL rm_state got %0d exp 0", state_dbg); end
        checks++; if (bmem_write !== 1'b0) begin errors++; $display("FAIL rm_write got %0b exp 0", bmem_write); end
        checks++; if (bmem_addr !== 32'd0) begin errors++; $display("FAIL rm_addr got %h exp 0", bmem_addr); end
        checks++; if (bmem_wdata !== 64'd0) begin errors++; $display("FAIL rm_wdata got %h exp 0", bmem_wdata); end
        checks++; if (dfp_rdata !== 256'd0) begin errors++; $display("FAIL rm_rdata got %h exp 0", dfp_rdata); end
        bmem_raddr  = 32'h0000_5000;
        bmem_rvalid = 1'b1;                        // late beats after reset
        bmem_rdata  = 64'hFEED_FEED_FEED_FEED;
        tick;
        tick;
        tick;
        bmem_rvalid = 1'b0;
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL rm_stray_state got %0d exp 0", state_dbg); end
        checks++; if (bmem_read !== 1'b0) begin errors++; $display("FAIL rm_stray_read got %0b exp 0", bmem_read); end
        bmem_ready = 1'b1;
        dfp_addr   = 32'h0000_5000;
        dfp_read   = 1'b1;                         // cycle 0
        tick;                                      // cycle 1
        for (int i = 0; i < 4; i++) begin
            tick;
            bmem_rvalid = 1'b1;
            bmem_rdata  = b[i];
        end
        tick;                                      // cycle 6
        bmem_rvalid = 1'b0;
        checks++; if (dfp_resp !== 1'b1) begin errors++; $display("FAIL rm_read_resp got %0b exp 1", dfp_resp); end
        checks++; if (dfp_rdata !== exp_line) begin errors++; $display("FAIL rm_read_line got %h exp %h", dfp_rdata, exp_line); end
        dfp_read = 1'b0;
        tick;
    endtask

`ifdef CACHELINE_ADAPTER_RADDR_FILTER_EN
    task automatic test_raddr_filter;
        logic [63:0]  b [4];
        logic [63:0]  beat_d [5];
        logic [31:0]  beat_a [5];
        logic [255:0] exp_line;
        b[0] = 64'h0400_0000_0000_0000; b[1] = 64'h0400_1111_1111_1111;
        b[2] = 64'h0400_2222_2222_2222; b[3] = 64'h0400_3333_3333_3333;
        beat_d[0] = b[0]; beat_d[1] = b[1]; beat_d[2] = 64'h0500_BAD0_BAD0_BAD0;
        beat_d[3] = b[2]; beat_d[4] = b[3];
        beat_a[0] = 32'h400; beat_a[1] = 32'h400; beat_a[2] = 32'h500;
        beat_a[3] = 32'h400; beat_a[4] = 32'h400;
        exp_line = {b[3], b[2], b[1], b[0]};
        bmem_ready = 1'b1;
        dfp_addr   = 32'h0000_0400;
        dfp_read   = 1'b1;                         // cycle 0
        tick;                                      // cycle 1
        for (int i = 0; i < 5; i++) begin          // cycles 2..6
            tick;
            bmem_rvalid = 1'b1;
            bmem_raddr  = beat_a[i];
            bmem_rdata  = beat_d[i];
            if (i == 4) begin
                checks++; if (dfp_resp !== 1'b0) begin errors++; $display("FAIL flt_resp_early got %0b exp 0", dfp_resp); end
            end
        end
        tick;                                      // cycle 7
        bmem_rvalid = 1'b0;
        checks++; if (dfp_resp !== 1'b1) begin errors++; $display("FAIL flt_resp got %0b exp 1", dfp_resp); end
        checks++; if (dfp_rdata !== exp_line) begin errors++; $display("FAIL flt_line got %h exp %h", dfp_rdata, exp_line); end
        dfp_read = 1'b0;
        tick;
    endtask
`endif

    initial begin
        rst         = 1'b1;
        dfp_addr    = '0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        dfp_wdata   = '0;
        bmem_ready  = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        test_reset;
        test_read_basic;
        test_write_stall;
        test_read_stalls;
        test_both_requests;
        test_reset_mid_burst;
`ifdef CACHELINE_ADAPTER_RADDR_FILTER_EN
        test_raddr_filter;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
Memory-side stage directly downstream of the data cache's dfp port. Converts one 256-bit cacheline read or write into a 4-beat, 64-bit burst on the banked-memory interface. Returns a single-cycle dfp_resp when the line transfer completes. One transaction in flight at a time; no internal queuing.

Parameters:
LINE_BITS, 256, cacheline width on dfp side
BEAT_BITS, 64, burst beat width on memory side
BEATS, LINE_BITS/BEAT_BITS (4), beats per burst; must be a power of two >= 2
OFFSET_BITS, $clog2(LINE_BITS/8) (5), byte-offset bits cleared for line alignment

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
dfp_addr  in  32  line address from cache; low OFFSET_BITS ignored
dfp_read  in  1  line read request; held until dfp_resp
dfp_write  in  1  line write request; held until dfp_resp
dfp_wdata  in  LINE_BITS  line to write; sampled in IDLE
dfp_rdata  out  LINE_BITS  assembled read line; valid while dfp_resp=1
dfp_resp  out  1  transaction done; one-cycle pulse
bmem_addr  out  32  line-aligned burst address
bmem_read  out  1  burst read command
bmem_write  out  1  write beat valid
bmem_wdata  out  BEAT_BITS  write beat data
bmem_ready  in  1  memory accepts command/beat this cycle
bmem_raddr  in  32  address tag of returning read beat
bmem_rdata  in  BEAT_BITS  read beat data
bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset values: dfp_resp=0, dfp_rdata=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0; state=IDLE, beat counter=0, line buffers=0.
- States: IDLE, RD_REQ, RD_DATA, WR_BURST, RESP.
- IDLE: if dfp_write, latch {dfp_addr[31:OFFSET_BITS], 0} and dfp_wdata, go WR_BURST. Else if dfp_read, latch aligned address, go RD_REQ. Write has priority if both are asserted.
- RD_REQ: bmem_read=1, bmem_addr=latched address. Stay until bmem_ready=1. On accept, go RD_DATA with counter=0. bmem_read is high only in RD_REQ.
- RD_DATA: on each bmem_rvalid, store bmem_rdata at line bits [counter*BEAT_BITS +: BEAT_BITS] and increment counter. On beat BEATS-1, go RESP. Cycles without rvalid hold state. Beats need not be contiguous.
- WR_BURST: bmem_write=1, bmem_addr=latched address, bmem_wdata=latched line beat[counter].
  - bmem_ready=1: beat is accepted and counter increments.
  - bmem_ready=0: beat, address and counter all hold.
  - After beat BEATS-1 is accepted, go RESP.
- RESP: dfp_resp=1 for exactly one cycle. dfp_rdata drives the assembled line; it holds that value afterwards until the next read completes. Then go IDLE.
- A request is sampled only in IDLE, so the earliest next request is accepted the cycle after RESP. Requests still asserted in that IDLE cycle start a new transaction; the cache must drop them on resp.
- Latency with memory always ready and zero-wait data:
  - Write: accepted at cycle 0, beats at cycles 1..4, resp at cycle 5.
  - Read: accepted at cycle 0, bmem_read at cycle 1, beats at cycles 2..5, resp at cycle 6.
- bmem_rvalid outside RD_DATA is ignored and leaves no state.
- dfp_addr, dfp_wdata and request changes after acceptance are ignored.
- Reset mid-burst: next cycle IDLE, all outputs at reset values, counter cleared. Late beats after reset are ignored. Partial writes already issued are not retracted.
- Counter is $clog2(BEATS) bits and wraps to 0 on the final beat.

Optional Feature:
CACHELINE_ADAPTER_RADDR_FILTER_EN
- Defined: in RD_DATA, a beat is accepted only if bmem_raddr[31:OFFSET_BITS] equals the latched line address. Mismatched beats are dropped and the counter does not advance.
- Undefined: bmem_raddr is ignored, and every rvalid in RD_DATA is accepted in order.

Test Plan:
- Read, addr 0x0000_1234, ready=1, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back -> bmem_addr=0x0000_1220. dfp_resp at cycle 6. dfp_rdata={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write, addr 0x8000_0040, wdata=beats {D3,D2,D1,D0}, ready low for 2 cycles on beat 1 -> bmem_wdata sequence D0,D1,D1,D1,D2,D3. bmem_addr held at 0x8000_0040 throughout. dfp_resp at cycle 7.
- Read with ready=0 for 3 cycles in RD_REQ and rvalid gaps between beats -> bmem_read held for 4 cycles then drops. Line is correct; exactly one dfp_resp pulse.
- dfp_read and dfp_write both high in IDLE -> write burst executes and bmem_read never asserts.
- rst asserted after 2 write beats, then stray rvalid beats -> outputs zero the next cycle and stay IDLE. A following read returns a clean correct line.
- With CACHELINE_ADAPTER_RADDR_FILTER_EN: a beat tagged raddr 0x0000_0500 interleaved into a read of 0x0000_0400 -> beat dropped and the line contains only the 4 matching beats.
